csr_irq_unit: RTL and testbench

//  Parametrised M-mode CSR file with interrupt controller, WFI stall FSM, MRET and perf counters.

---
 rtl/csr_irq_unit_pkg.sv | 26 ++
 rtl/csr_irq_arbiter.sv | 22 ++
 rtl/csr_irq_unit.sv | 159 +++++++++++++++
 tb/tb_csr_irq_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_irq_unit_pkg.sv
// Shared definitions for csr_irq_unit: CSR addresses, mstatus bit positions,
// interrupt cause base and the WFI FSM state type.
package csr_irq_unit_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MCAUSE_IRQ_BASE  = 16;
  localparam int IRQ_IDX_W        = 4;

  typedef enum logic {
    CSR_RUN,
    CSR_WFI
  } csr_state_e;

endpackage

// File: rtl/csr_irq_arbiter.sv
// Fixed-priority encoder: reports whether any source is pending and the
// lowest pending index.
module csr_irq_arbiter
  import csr_irq_unit_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0]   pend,
  output logic                 valid,
  output logic [IRQ_IDX_W-1:0] idx
);

  always_comb begin
    valid = |pend;
    idx   = '0;
    // Walk downward so the lowest set bit is the last one written.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) idx = IRQ_IDX_W'(i);
    end
  end

endmodule

// File: rtl/csr_irq_unit.sv
// M-mode CSR file with level-sensitive interrupt controller, WFI stall FSM,
// MRET handling and optional perf counters (enabled by CSR_PERF_CNT_EN).
module csr_irq_unit
  import csr_irq_unit_pkg::*;
#(
  parameter int               XLEN      = 32,
  parameter int               NUM_IRQ   = 4,
  parameter logic [XLEN-1:0]  MTVEC_RST = 32'h0001_0000
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               csr_we,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  input  logic               csr_wfi,
  input  logic               csr_mret,
  input  logic               inst_retire,
  input  logic [XLEN-1:0]    curr_pc,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               trap_take,
  output logic [XLEN-1:0]    trap_pc,
  output logic [XLEN-1:0]    ret_pc,
  output logic               csr_stall,
  output csr_state_e         fsm_state
);

  csr_state_e           state_q, state_d;
  logic                 mstatus_mie, mstatus_mpie;
  logic [NUM_IRQ-1:0]   mie_irq, mip_irq;
  logic [XLEN-1:0]      mtvec_q, mepc_q, mcause_q;
  logic [NUM_IRQ-1:0]   pend;
  logic                 pend_any;
  logic [IRQ_IDX_W-1:0] irq_idx;
  logic [XLEN-1:0]      trap_cause;
  logic                 csr_wr;

  assign pend = mip_irq & mie_irq;

  csr_irq_arbiter #(.NUM_IRQ(NUM_IRQ)) u_arbiter (
    .pend  (pend),
    .valid (pend_any),
    .idx   (irq_idx)
  );

  assign trap_take = mstatus_mie & pend_any;
  assign trap_pc   = {mtvec_q[XLEN-1:2], 2'b00};
  assign ret_pc    = mepc_q;
  // Traps and MRET both pre-empt a same-cycle CSR write entirely.
  assign csr_wr    = csr_we & ~trap_take & ~csr_mret;

  always_comb begin
    trap_cause         = '0;
    trap_cause[XLEN-1] = 1'b1;
    trap_cause[7:0]    = 8'(MCAUSE_IRQ_BASE) + 8'(irq_idx);
  end

  // WFI FSM: wake on any enabled pending source, regardless of MIE.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= CSR_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    csr_stall = 1'b0;
    case (state_q)
      CSR_RUN: if (csr_wfi && !pend_any) state_d = CSR_WFI;
      CSR_WFI: begin
        csr_stall = 1'b1;
        if (pend_any) state_d = CSR_RUN;
      end
      default: state_d = CSR_RUN;
    endcase
  end

  assign fsm_state = state_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_irq      <= '0;
      mip_irq      <= '0;
      mtvec_q      <= MTVEC_RST;
      mepc_q       <= '0;
      mcause_q     <= '0;
    end else begin
      mip_irq <= irq_i;
      if (trap_take) begin
        mepc_q       <= (state_q == CSR_WFI) ? curr_pc + XLEN'(4) : curr_pc;
        mcause_q     <= trap_cause;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (csr_mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (csr_wr) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mstatus_mie  <= csr_wdata[MSTATUS_MIE_BIT];
            mstatus_mpie <= csr_wdata[MSTATUS_MPIE_BIT];
          end
          CSR_MIE:    mie_irq  <= csr_wdata[MCAUSE_IRQ_BASE +: NUM_IRQ];
          CSR_MTVEC:  mtvec_q  <= csr_wdata;
          CSR_MEPC:   mepc_q   <= csr_wdata;
          CSR_MCAUSE: mcause_q <= csr_wdata;
          default: ;
        endcase
      end
    end
  end

`ifdef CSR_PERF_CNT_EN
  logic [2*XLEN-1:0] mcycle_q, minstret_q;

  // A write to either half replaces it and skips that cycle's increment.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (csr_wr && csr_addr == CSR_MCYCLE)       mcycle_q[XLEN-1:0]      <= csr_wdata;
      else if (csr_wr && csr_addr == CSR_MCYCLEH) mcycle_q[2*XLEN-1:XLEN] <= csr_wdata;
      else                                        mcycle_q <= mcycle_q + 1'b1;

      if (csr_wr && csr_addr == CSR_MINSTRET)       minstret_q[XLEN-1:0]      <= csr_wdata;
      else if (csr_wr && csr_addr == CSR_MINSTRETH) minstret_q[2*XLEN-1:XLEN] <= csr_wdata;
      else                                          minstret_q <= minstret_q + (2*XLEN)'(inst_retire);
    end
  end
`else
  logic unused_retire;
  assign unused_retire = inst_retire;
`endif

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MIE_BIT]  = mstatus_mie;
        csr_rdata[MSTATUS_MPIE_BIT] = mstatus_mpie;
      end
      CSR_MIE:       csr_rdata[MCAUSE_IRQ_BASE +: NUM_IRQ] = mie_irq;
      CSR_MIP:       csr_rdata[MCAUSE_IRQ_BASE +: NUM_IRQ] = mip_irq;
      CSR_MTVEC:     csr_rdata = mtvec_q;
      CSR_MEPC:      csr_rdata = mepc_q;
      CSR_MCAUSE:    csr_rdata = mcause_q;
`ifdef CSR_PERF_CNT_EN
      CSR_MCYCLE:    csr_rdata = mcycle_q[XLEN-1:0];
      CSR_MCYCLEH:   csr_rdata = mcycle_q[2*XLEN-1:XLEN];
      CSR_MINSTRET:  csr_rdata = minstret_q[XLEN-1:0];
      CSR_MINSTRETH: csr_rdata = minstret_q[2*XLEN-1:XLEN];
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_irq_unit.sv
// Self-checking bench for csr_irq_unit: CSR map, traps, MRET, WFI, priority,
// counters (when CSR_PERF_CNT_EN is defined) and reset during WFI.
module tb_csr_irq_unit;
  import csr_irq_unit_pkg::*;

  localparam int XLEN    = 32;
  localparam int NUM_IRQ = 4;

  logic               clk, rstn;
  logic               csr_we, csr_wfi, csr_mret, inst_retire;
  logic [11:0]        csr_addr;
  logic [XLEN-1:0]    csr_wdata, csr_rdata, curr_pc, trap_pc, ret_pc;
  logic [NUM_IRQ-1:0] irq_i;
  logic               trap_take, csr_stall;
  csr_state_e         fsm_state;

  int n_checks   = 0;
  int n_fail     = 0;
  int trap_count = 0;

  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] trap_exp_q[$];

  csr_irq_unit #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ), .MTVEC_RST(32'h0001_0000)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .csr_we      (csr_we),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .csr_wfi     (csr_wfi),
    .csr_mret    (csr_mret),
    .inst_retire (inst_retire),
    .curr_pc     (curr_pc),
    .irq_i       (irq_i),
    .trap_take   (trap_take),
    .trap_pc     (trap_pc),
    .ret_pc      (ret_pc),
    .csr_stall   (csr_stall),
    .fsm_state   (fsm_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [XLEN-1:0] got,
                          input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Trap scoreboard: each expected trap pushes its ISR address beforehand.
  always @(negedge clk) begin
    if (rstn && trap_take === 1'b1) begin
      trap_count++;
      check_eq("trap_expected", 32'(trap_exp_q.size() != 0), 32'd1);
      if (trap_exp_q.size() != 0) check_eq("trap_pc", trap_pc, trap_exp_q.pop_front());
    end
  end

  // Driver tasks
  task automatic peek(input string tag, input logic [11:0] addr, input logic [XLEN-1:0] exp);
    exp_q.push_back(exp);
    csr_addr = addr;
    #1;
    check_eq(tag, csr_rdata, exp_q.pop_front());
  endtask

  task automatic read_chk(input string tag, input logic [11:0] addr, input logic [XLEN-1:0] exp);
    @(negedge clk);
    peek(tag, addr, exp);
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [XLEN-1:0] data);
    @(negedge clk);
    csr_we    = 1'b1;
    csr_addr  = addr;
    csr_wdata = data;
    @(negedge clk);
    csr_we    = 1'b0;
    csr_wdata = '0;
  endtask

  task automatic wait_trap(input int target, input string tag);
    int i = 0;
    while (trap_count < target && i < 10) begin
      @(posedge clk);
      i++;
    end
    check_eq(tag, 32'(trap_count), 32'(target));
  endtask

  initial begin
    rstn = 1'b0; csr_we = 1'b0; csr_wfi = 1'b0; csr_mret = 1'b0; inst_retire = 1'b0;
    csr_addr = '0; csr_wdata = '0; curr_pc = '0; irq_i = '0;

    // 1: reset values
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_stall", 32'(csr_stall), 32'd0);
    check_eq("rst_trap_take", 32'(trap_take), 32'd0);
    peek("rst_mtvec", CSR_MTVEC, 32'h0001_0000);
    peek("rst_mstatus", CSR_MSTATUS, 32'h0);
    rstn = 1'b1;

    // 2: interrupt trap then MRET
    csr_write(CSR_MIE, 32'h0002_0000);
    csr_write(CSR_MSTATUS, 32'h8);
    @(negedge clk);
    curr_pc = 32'h100;
    trap_exp_q.push_back(32'h0001_0000);
    irq_i = 4'b0010;
    wait_trap(1, "irq_trap_seen");
    @(negedge clk);
    irq_i = '0;
    read_chk("irq_mepc", CSR_MEPC, 32'h100);
    read_chk("irq_mcause", CSR_MCAUSE, 32'h8000_0011);
    read_chk("irq_mstatus", CSR_MSTATUS, 32'h80);
    @(negedge clk);
    csr_mret = 1'b1;
    #1;
    check_eq("mret_ret_pc", ret_pc, 32'h100);
    @(negedge clk);
    csr_mret = 1'b0;
    peek("mret_mstatus", CSR_MSTATUS, 32'h88);
    csr_write(CSR_MSTATUS, 32'h0);

    // 3: WFI with MIE=0 wakes without trapping
    @(negedge clk);
    curr_pc = 32'h200;
    csr_wfi = 1'b1;
    @(negedge clk);
    csr_wfi = 1'b0;
    #1;
    check_eq("wfi_stall", 32'(csr_stall), 32'd1);
    check_eq("wfi_state", 32'(fsm_state), 32'(CSR_WFI));
    repeat (2) @(negedge clk);
    check_eq("wfi_hold", 32'(csr_stall), 32'd1);
    irq_i = 4'b0010;
    @(negedge clk);
    check_eq("wfi_latch_cycle", 32'(csr_stall), 32'd1);
    @(negedge clk);
    check_eq("wfi_wake", 32'(csr_stall), 32'd0);
    check_eq("wfi_wake_state", 32'(fsm_state), 32'(CSR_RUN));
    irq_i = '0;
    read_chk("wfi_mepc_kept", CSR_MEPC, 32'h100);
    check_eq("wfi_no_trap", 32'(trap_count), 32'd1);

    // mip reflection, mtvec masking, unmapped and read-only bits
    @(negedge clk);
    irq_i = 4'b0001;
    read_chk("mip_read", CSR_MIP, 32'h0001_0000);
    irq_i = '0;
    csr_write(CSR_MTVEC, 32'h0002_0007);
    read_chk("mtvec_read", CSR_MTVEC, 32'h0002_0007);
    check_eq("trap_pc_mask", trap_pc, 32'h0002_0004);
    csr_write(12'h7C0, 32'hFFFF_FFFF);
    read_chk("unmapped_read", 12'h7C0, 32'h0);
    csr_write(CSR_MSTATUS, 32'hFFFF_FFF7);
    read_chk("mstatus_ro_bits", CSR_MSTATUS, 32'h80);
    csr_write(CSR_MSTATUS, 32'h0);

    // 4: lowest index wins; same-cycle MRET and mepc write are dropped
    csr_write(CSR_MIE, 32'h000F_0000);
    csr_write(CSR_MSTATUS, 32'h8);
    @(negedge clk);
    curr_pc = 32'h300;
    trap_exp_q.push_back(32'h0002_0004);
    irq_i = 4'b1010;
    @(negedge clk);
    csr_we = 1'b1; csr_addr = CSR_MEPC; csr_wdata = 32'hDEAD_BEEC; csr_mret = 1'b1;
    @(negedge clk);
    csr_we = 1'b0; csr_mret = 1'b0; irq_i = '0;
    check_eq("prio_trap_seen", 32'(trap_count), 32'd2);
    read_chk("prio_mepc", CSR_MEPC, 32'h300);
    read_chk("prio_mcause", CSR_MCAUSE, 32'h8000_0011);
    read_chk("prio_mstatus", CSR_MSTATUS, 32'h80);

    // Trap taken while stalled in WFI: mepc points past the WFI
    csr_write(CSR_MSTATUS, 32'h8);
    @(negedge clk);
    curr_pc = 32'h400;
    csr_wfi = 1'b1;
    @(negedge clk);
    csr_wfi = 1'b0;
    #1;
    check_eq("wfi_trap_stall", 32'(csr_stall), 32'd1);
    trap_exp_q.push_back(32'h0002_0004);
    irq_i = 4'b0100;
    wait_trap(3, "wfi_trap_seen");
    @(negedge clk);
    irq_i = '0;
    check_eq("wfi_trap_wake", 32'(csr_stall), 32'd0);
    read_chk("wfi_trap_mepc", CSR_MEPC, 32'h404);
    read_chk("wfi_trap_mcause", CSR_MCAUSE, 32'h8000_0012);
    read_chk("wfi_trap_mstatus", CSR_MSTATUS, 32'h80);

    // 5: performance counters
`ifdef CSR_PERF_CNT_EN
    @(negedge clk);
    csr_we = 1'b1; csr_addr = CSR_MCYCLE; csr_wdata = 32'hFFFF_FFFE;
    @(negedge clk);
    csr_we = 1'b0;
    peek("mcycle_written", CSR_MCYCLE, 32'hFFFF_FFFE);
    @(negedge clk);
    peek("mcycle_plus1", CSR_MCYCLE, 32'hFFFF_FFFF);
    @(negedge clk);
    peek("mcycle_carry_lo", CSR_MCYCLE, 32'h0);
    peek("mcycle_carry_hi", CSR_MCYCLEH, 32'h1);
    @(negedge clk);
    csr_we = 1'b1; csr_addr = CSR_MINSTRET; csr_wdata = 32'h5;
    inst_retire = 1'b1;
    @(negedge clk);
    csr_we = 1'b0;
    repeat (3) @(negedge clk);
    inst_retire = 1'b0;
    peek("minstret_count", CSR_MINSTRET, 32'h8);
`else
    csr_write(CSR_MCYCLE, 32'hFFFF_FFFE);
    read_chk("mcycle_absent", CSR_MCYCLE, 32'h0);
    read_chk("mcycleh_absent", CSR_MCYCLEH, 32'h0);
    read_chk("minstret_absent", CSR_MINSTRET, 32'h0);
`endif

    // 6: reset while stalled in WFI
    csr_write(CSR_MSTATUS, 32'h0);
    @(negedge clk);
    csr_wfi = 1'b1;
    @(negedge clk);
    csr_wfi = 1'b0;
    #1;
    check_eq("rst_wfi_pre", 32'(csr_stall), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    #1;
    check_eq("rst_wfi_stall", 32'(csr_stall), 32'd0);
    check_eq("rst_wfi_state", 32'(fsm_state), 32'(CSR_RUN));
    rstn = 1'b1;
    read_chk("rst_wfi_mtvec", CSR_MTVEC, 32'h0001_0000);
    read_chk("rst_wfi_mie", CSR_MIE, 32'h0);
    read_chk("rst_wfi_mepc", CSR_MEPC, 32'h0);

    check_eq("trap_queue_empty", 32'(trap_exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
